// File: rtl/morse_char_sequencer_if.sv
// Event input and character output bundle between the sequencer and its neighbours.
// The slave side is the sequencer; the master side drives events and char_ready.
interface morse_char_sequencer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [2:0]       pulse_event;
    logic [7:0]       char_data;
    logic             char_valid;
    logic             char_ready;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic             busy;

    modport master (
        output pulse_event, char_ready,
        input  char_data, char_valid, fifo_count, overflow, busy
    );

    modport slave (
        input  pulse_event, char_ready,
        output char_data, char_valid, fifo_count, overflow, busy
    );
endinterface

// File: rtl/morse_char_sequencer.sv
// Morse dit/dash events -> ASCII chars in a FWFT FIFO; terminating space at edge N shows at edge N+2.
// Consumer stalls via char_ready; pushes into a full FIFO are dropped and flagged by sticky overflow.
module morse_char_sequencer #(
    parameter int MAX_SYMBOLS = 5,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clock_1khz,
    input  logic                   rst,
    morse_char_sequencer_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_SYMBOLS + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_SYMBOLS + 1);

    localparam logic [2:0] EV_DIT  = 3'b001;
    localparam logic [2:0] EV_DASH = 3'b010;
    localparam logic [2:0] EV_LTR  = 3'b011;
    localparam logic [2:0] EV_WORD = 3'b100;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT_LETTER, EMIT_SPACE} state_t;

    state_t                 state_q, state_d;
    logic [MAX_SYMBOLS-1:0] sym_q, sym_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   last_letter_q, last_letter_d;
    logic                   pending_space_q, pending_space_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [2:0]             hold_dat_q, hold_dat_d;

    logic                   in_vld;
    logic                   ev_vld;
    logic [2:0]             ev;
    logic                   push_vld;
    logic [7:0]             push_dat;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overflow_q;
    logic                   fifo_full, fifo_empty, pop, push_ok;

    // Key is {len, pattern} with dash=1 and the first element most significant.
    function automatic logic [7:0] decode(input logic [MAX_SYMBOLS-1:0] s,
                                          input logic [LEN_W-1:0] l);
        logic [7:0] key;
        if (l == '0 || int'(l) > 5) return 8'h3F;
        key = {3'(l), 5'(s)};
        case (key)
            8'b001_00000: return "E";  8'b001_00001: return "T";
            8'b010_00000: return "I";  8'b010_00001: return "A";
            8'b010_00010: return "N";  8'b010_00011: return "M";
            8'b011_00000: return "S";  8'b011_00001: return "U";
            8'b011_00010: return "R";  8'b011_00011: return "W";
            8'b011_00100: return "D";  8'b011_00101: return "K";
            8'b011_00110: return "G";  8'b011_00111: return "O";
            8'b100_00000: return "H";  8'b100_00001: return "V";
            8'b100_00010: return "F";  8'b100_00100: return "L";
            8'b100_00110: return "P";  8'b100_00111: return "J";
            8'b100_01000: return "B";  8'b100_01001: return "X";
            8'b100_01010: return "C";  8'b100_01011: return "Y";
            8'b100_01100: return "Z";  8'b100_01101: return "Q";
            8'b101_00000: return "5";  8'b101_00001: return "4";
            8'b101_00011: return "3";  8'b101_00111: return "2";
            8'b101_01111: return "1";  8'b101_11111: return "0";
            8'b101_10000: return "6";  8'b101_11000: return "7";
            8'b101_11100: return "8";  8'b101_11110: return "9";
            default:      return 8'h3F;
        endcase
    endfunction

    assign in_vld = (bus.pulse_event != 3'b000) && (bus.pulse_event <= EV_WORD);

    always_ff @(posedge clock_1khz) begin
        if (!rst) begin
            state_q         <= IDLE;
            sym_q           <= '0;
            len_q           <= '0;
            last_letter_q   <= 1'b0;
            pending_space_q <= 1'b0;
            hold_vld_q      <= 1'b0;
            hold_dat_q      <= 3'b000;
        end else begin
            state_q         <= state_d;
            sym_q           <= sym_d;
            len_q           <= len_d;
            last_letter_q   <= last_letter_d;
            pending_space_q <= pending_space_d;
            hold_vld_q      <= hold_vld_d;
            hold_dat_q      <= hold_dat_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        sym_d           = sym_q;
        len_d           = len_q;
        last_letter_d   = last_letter_q;
        pending_space_d = pending_space_q;
        hold_vld_d      = hold_vld_q;
        hold_dat_d      = hold_dat_q;
        ev              = hold_vld_q ? hold_dat_q : bus.pulse_event;
        ev_vld          = hold_vld_q | in_vld;
        case (state_q)
            IDLE, COLLECT: begin
                // A held event goes first; a fresh one queues behind it.
                if (hold_vld_q) begin
                    hold_vld_d = in_vld;
                    hold_dat_d = bus.pulse_event;
                end
                if (ev_vld) begin
                    case (ev)
                        EV_DIT, EV_DASH: begin
                            if (state_q == IDLE) begin
                                sym_d = {{(MAX_SYMBOLS-1){1'b0}}, ev == EV_DASH};
                                len_d = LEN_W'(1);
                            end else begin
                                sym_d = {sym_q[MAX_SYMBOLS-2:0], ev == EV_DASH};
                                if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
                            end
                            state_d = COLLECT;
                        end
                        EV_LTR: if (state_q == COLLECT) state_d = EMIT_LETTER;
                        EV_WORD: begin
                            if (state_q == COLLECT) begin
                                state_d         = EMIT_LETTER;
                                pending_space_d = 1'b1;
                            end else if (last_letter_q) begin
                                state_d = EMIT_SPACE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            EMIT_LETTER: begin
                if (in_vld) begin
                    hold_vld_d = 1'b1;
                    hold_dat_d = bus.pulse_event;
                end
                sym_d         = '0;
                len_d         = '0;
                last_letter_d = 1'b1;
                state_d       = pending_space_q ? EMIT_SPACE : IDLE;
            end
            EMIT_SPACE: begin
                if (in_vld) begin
                    hold_vld_d = 1'b1;
                    hold_dat_d = bus.pulse_event;
                end
                last_letter_d   = 1'b0;
                pending_space_d = 1'b0;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_vld = 1'b0;
        push_dat = 8'h00;
        case (state_q)
            EMIT_LETTER: begin
                push_vld = 1'b1;
                push_dat = decode(sym_q, len_q);
            end
            EMIT_SPACE: begin
                push_vld = 1'b1;
                push_dat = 8'h20;
            end
            default: ;
        endcase
        bus.busy = (state_q != IDLE) | hold_vld_q;
    end

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus.char_ready;
    assign push_ok    = push_vld && (!fifo_full || pop);

    always_ff @(posedge clock_1khz) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clock_1khz) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
            if (push_vld && !push_ok) overflow_q <= 1'b1;
        end
    end

    assign bus.char_valid = !fifo_empty;
    assign bus.char_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_morse_char_sequencer.sv
// Randomized scoreboard bench: a string-keyed Morse model predicts characters; a monitor checks pops.
module tb_morse_char_sequencer;
    localparam int DEPTH = 8;
    localparam logic [2:0] EV_NONE = 3'd0, EV_DIT = 3'd1, EV_DASH = 3'd2,
                           EV_LTR = 3'd3, EV_WORD = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    morse_char_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus();

    morse_char_sequencer #(.MAX_SYMBOLS(5), .FIFO_DEPTH(DEPTH)) dut (
        .clock_1khz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int         total_cnt = 0;
    int         pass_cnt  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic [7:0] code_tbl [string];
    string      cur_sym     = "";
    bit         last_letter = 1'b0;
    bit         blocked     = 1'b0;
    int         blocked_cnt = 0;
    bit         exp_ovf     = 1'b0;
    bit         rand_ready  = 1'b0;

    string codes [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function logic [7:0] lookup(input string s);
        if (code_tbl.exists(s)) return code_tbl[s];
        return 8'h3F;
    endfunction

    // With char_ready held low the FIFO can only absorb DEPTH characters.
    function void exp_push(input logic [7:0] c);
        if (blocked) begin
            if (blocked_cnt < DEPTH) exp_q.push_back(c);
            else exp_ovf = 1'b1;
            blocked_cnt++;
        end else begin
            exp_q.push_back(c);
        end
    endfunction

    function void model_event(input logic [2:0] e);
        case (e)
            EV_DIT:  cur_sym = {cur_sym, "."};
            EV_DASH: cur_sym = {cur_sym, "-"};
            EV_LTR: if (cur_sym.len() > 0) begin
                exp_push(lookup(cur_sym));
                cur_sym     = "";
                last_letter = 1'b1;
            end
            EV_WORD: begin
                if (cur_sym.len() > 0) begin
                    exp_push(lookup(cur_sym));
                    exp_push(8'h20);
                    cur_sym = "";
                end else if (last_letter) begin
                    exp_push(8'h20);
                end
                last_letter = 1'b0;
            end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst && bus.char_valid && bus.char_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_char: got 0x%0h, expected no character", bus.char_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("char_data", {24'h0, bus.char_data}, {24'h0, mon_exp});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.char_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [2:0] e);
        bus.pulse_event = e;
        model_event(e);
        tick();
        bus.pulse_event = EV_NONE;
    endtask

    task automatic send_code(input string s, input logic [2:0] term);
        for (int i = 0; i < s.len(); i++) begin
            send((s.getc(i) == "-") ? EV_DASH : EV_DIT);
            idle($urandom_range(0, 2));
        end
        send(term);
        idle($urandom_range(3, 5));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.pulse_event = EV_NONE;
        repeat (n) tick();
        cur_sym     = "";
        last_letter = 1'b0;
        exp_q.delete();
        exp_ovf     = 1'b0;
        blocked     = 1'b0;
        blocked_cnt = 0;
        rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'h0, bus.char_data}, 32'h00);
        check({tag, "_valid"}, {31'h0, bus.char_valid}, 32'h0);
        check({tag, "_count"}, 32'(bus.fifo_count), 32'h0);
        check({tag, "_ovf"},   {31'h0, bus.overflow}, 32'h0);
        check({tag, "_busy"},  {31'h0, bus.busy}, 32'h0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        rand_ready     = 1'b0;
        bus.char_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.char_valid) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_left_expected"}, 32'(exp_q.size()), 32'h0);
        check({tag, "_count"}, 32'(bus.fifo_count), 32'h0);
    endtask

    initial begin
        string junk;
        int    r;
        for (int i = 0; i < 26; i++) code_tbl[codes[i]] = 8'h41 + 8'(i);
        for (int i = 0; i < 10; i++) code_tbl[codes[26 + i]] = 8'h30 + 8'(i);
        bus.pulse_event = EV_NONE;
        bus.char_ready  = 1'b0;

        do_reset(3);
        check_reset_outputs("reset");

        // 'E' latency: letter space sampled at edge N, char present after edge N+1.
        send(EV_DIT);
        idle(1);
        bus.pulse_event = EV_LTR;
        model_event(EV_LTR);
        tick();
        bus.pulse_event = EV_NONE;
        check("lat_n_valid", {31'h0, bus.char_valid}, 32'h0);
        check("lat_n_busy",  {31'h0, bus.busy}, 32'h1);
        tick();
        check("lat_n1_valid", {31'h0, bus.char_valid}, 32'h1);
        check("lat_n1_data",  {24'h0, bus.char_data}, 32'h45);
        check("lat_n1_count", 32'(bus.fifo_count), 32'h1);

        send_code(".-", EV_LTR);
        send_code("---", EV_LTR);
        check("ao_count", 32'(bus.fifo_count), 32'h3);
        check("ao_head",  {24'h0, bus.char_data}, 32'h45);
        drain("eao");

        send_code("...", EV_WORD);
        drain("s_space");

        send_code("......", EV_LTR);
        drain("too_long");

        do_reset(2);
        send(EV_WORD);
        send(EV_LTR);
        idle(4);
        check("lead_space_count", 32'(bus.fifo_count), 32'h0);
        check("lead_space_busy",  {31'h0, bus.busy}, 32'h0);

        // Nine letters against a stalled consumer: the ninth must be dropped.
        bus.char_ready = 1'b0;
        blocked        = 1'b1;
        blocked_cnt    = 0;
        for (int i = 0; i < 9; i++) send_code(codes[i], EV_LTR);
        check("ovf_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("ovf_flag",  {31'h0, bus.overflow}, {31'h0, exp_ovf});
        check("ovf_head",  {24'h0, bus.char_data}, 32'h41);
        blocked = 1'b0;
        drain("ovf");
        check("ovf_sticky", {31'h0, bus.overflow}, {31'h0, exp_ovf});
        do_reset(1);
        check_reset_outputs("ovf_reset");

        // Events landing while a letter is being emitted are held and replayed.
        bus.char_ready = 1'b1;
        send(EV_DIT);
        send(EV_DIT);
        send(EV_LTR);
        send(EV_DIT);
        send(EV_DASH);
        send(EV_LTR);
        idle(5);
        check("hold_busy", {31'h0, bus.busy}, 32'h0);
        drain("hold");

        send(EV_DIT);
        send(EV_DIT);
        do_reset(1);
        check_reset_outputs("mid_reset");
        send(EV_LTR);
        idle(4);
        check("mid_reset_nochar", 32'(bus.fifo_count), 32'h0);

        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                junk = "";
                repeat ($urandom_range(6, 7)) begin
                    if ($urandom_range(0, 1) == 1) junk = {junk, "-"};
                    else junk = {junk, "."};
                end
                send_code(junk, EV_LTR);
            end else if (r == 1) begin
                send(EV_WORD);
                idle(3);
            end else if (r == 2) begin
                send(3'(5 + $urandom_range(0, 2)));
                idle(1);
            end else begin
                send_code(codes[$urandom_range(0, 35)], ($urandom_range(0, 2) == 0) ? EV_WORD : EV_LTR);
            end
        end
        drain("random");
        check("random_ovf", {31'h0, bus.overflow}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
